// File: rtl/ysyx_22050550_wbu.sv
// Write-back unit: latches one retired instruction from the LSU, then spends one
// COMMIT cycle driving GPR/CSR write ports and, for ecall/mret, a fetch redirect.
module ysyx_22050550_wbu (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_pc,
  input  logic [4:0]  in_rd,
  input  logic        in_rd_wen,
  input  logic [63:0] in_result,
  input  logic [2:0]  in_csr_op,
  input  logic [11:0] in_csr_addr,
  input  logic [63:0] in_csr_src,
  input  logic [63:0] mepc,
  input  logic [63:0] mcause,
  input  logic [63:0] mtvec,
  input  logic [63:0] mstatus,
  input  logic [63:0] mie,
  input  logic [63:0] mip,
  output logic [4:0]  io_waddr,
  output logic [63:0] io_wdata,
  output logic        io_wen,
  output logic        io_valid,
  output logic [63:0] pc,
  output logic [63:0] wbmepc,
  output logic [63:0] wbmcause,
  output logic [63:0] wbmtvec,
  output logic [63:0] wbmstatus,
  output logic [63:0] wbmie,
  output logic [63:0] wbmip,
  output logic [7:0]  wbcsren,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic        dbg_state
);

  // Handshake: an instruction transfers at a rising edge where in_valid and
  // in_ready are both high; in_ready is high only in IDLE and never in reset.

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_RW    = 3'd1;
  localparam logic [2:0] OP_RS    = 3'd2;
  localparam logic [2:0] OP_RC    = 3'd3;
  localparam logic [2:0] OP_ECALL = 3'd4;
  localparam logic [2:0] OP_MRET  = 3'd5;

  typedef enum logic {IDLE = 1'b0, COMMIT = 1'b1} state_t;

  state_t      state_q;
  logic [63:0] pc_q;
  logic [4:0]  rd_q;
  logic        rd_wen_q;
  logic [63:0] result_q;
  logic [2:0]  op_q;
  logic [11:0] addr_q;
  logic [63:0] src_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      rd_q     <= '0;
      rd_wen_q <= 1'b0;
      result_q <= '0;
      op_q     <= '0;
      addr_q   <= '0;
      src_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q  <= COMMIT;
            pc_q     <= in_pc;
            rd_q     <= in_rd;
            rd_wen_q <= in_rd_wen;
            result_q <= in_result;
            op_q     <= in_csr_op;
            addr_q   <= in_csr_addr;
            src_q    <= in_csr_src;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [2:0]  op_eff;
  logic        is_csr;
  logic        is_ecall;
  logic        is_mret;
  logic        commit;
  logic [5:0]  sel;
  logic [63:0] old_val;
  logic [63:0] new_val;
  logic        csr_we;
  logic [7:0]  en;
  logic [63:0] ecall_status;
  logic [63:0] mret_status;

  always_comb begin
    op_eff   = (op_q > OP_MRET) ? OP_NONE : op_q;
    is_csr   = (op_eff == OP_RW) || (op_eff == OP_RS) || (op_eff == OP_RC);
    is_ecall = (op_eff == OP_ECALL);
    is_mret  = (op_eff == OP_MRET);
    commit   = (state_q == COMMIT);

    // sel bit positions match the wbcsren layout
    case (addr_q)
      12'h341: begin old_val = mepc;    sel = 6'b000001; end
      12'h342: begin old_val = mcause;  sel = 6'b000010; end
      12'h305: begin old_val = mtvec;   sel = 6'b000100; end
      12'h300: begin old_val = mstatus; sel = 6'b001000; end
      12'h304: begin old_val = mie;     sel = 6'b010000; end
      12'h344: begin old_val = mip;     sel = 6'b100000; end
      default: begin old_val = '0;      sel = 6'b000000; end
    endcase

    case (op_eff)
      OP_RW:   new_val = src_q;
      OP_RS:   new_val = old_val | src_q;
      OP_RC:   new_val = old_val & ~src_q;
      default: new_val = old_val;
    endcase

    csr_we = is_csr && (sel != 6'd0) && ((op_eff == OP_RW) || (src_q != 64'd0));

    ecall_status        = mstatus;
    ecall_status[7]     = mstatus[3];
    ecall_status[3]     = 1'b0;
    ecall_status[12:11] = 2'b11;

    mret_status         = mstatus;
    mret_status[3]      = mstatus[7];
    mret_status[7]      = 1'b1;
    mret_status[12:11]  = 2'b11;

    wbmepc    = '0;
    wbmcause  = '0;
    wbmtvec   = '0;
    wbmstatus = '0;
    wbmie     = '0;
    wbmip     = '0;
    if (is_csr) begin
      if (sel[0]) wbmepc    = new_val;
      if (sel[1]) wbmcause  = new_val;
      if (sel[2]) wbmtvec   = new_val;
      if (sel[3]) wbmstatus = new_val;
      if (sel[4]) wbmie     = new_val;
      if (sel[5]) wbmip     = new_val;
    end
    if (is_ecall) begin
      wbmepc    = pc_q;
      wbmcause  = 64'd11;
      wbmstatus = ecall_status;
    end
    if (is_mret) wbmstatus = mret_status;

    if (csr_we)        en = {2'b00, sel};
    else if (is_ecall) en = 8'b0000_1011;
    else if (is_mret)  en = 8'b0000_1000;
    else               en = 8'b0000_0000;

    wbcsren        = commit ? en : 8'd0;
    io_waddr       = rd_q;
    io_wdata       = is_csr ? old_val : result_q;
    io_wen         = commit && rd_wen_q && (rd_q != 5'd0) && !is_ecall && !is_mret;
    io_valid       = commit;
    pc             = pc_q;
    redirect_valid = commit && (is_ecall || is_mret);
    if (is_ecall)     redirect_pc = mtvec & ~64'h3;
    else if (is_mret) redirect_pc = mepc;
    else              redirect_pc = '0;

    in_ready  = !reset && (state_q == IDLE);
    dbg_state = (state_q == COMMIT);
  end

endmodule

// File: tb/tb_ysyx_22050550_wbu.sv
// Directed bench for the write-back unit: stimulus pushes expected commits into a
// queue; a negedge monitor pops and compares whenever io_valid is presented.
module tb_ysyx_22050550_wbu;

  typedef struct packed {
    logic             wen;
    logic [4:0]       waddr;
    logic [63:0]      wdata;
    logic [63:0]      pc;
    logic [7:0]       csren;
    logic             rv;
    logic [63:0]      rpc;
    logic [5:0][63:0] wb;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_pc = '0;
  logic [4:0]  in_rd = '0;
  logic        in_rd_wen = 1'b0;
  logic [63:0] in_result = '0;
  logic [2:0]  in_csr_op = '0;
  logic [11:0] in_csr_addr = '0;
  logic [63:0] in_csr_src = '0;
  logic [63:0] mepc = '0, mcause = '0, mtvec = '0, mstatus = '0, mie = '0, mip = '0;
  logic [4:0]  io_waddr;
  logic [63:0] io_wdata;
  logic        io_wen, io_valid;
  logic [63:0] pc;
  logic [63:0] wbmepc, wbmcause, wbmtvec, wbmstatus, wbmie, wbmip;
  logic [7:0]  wbcsren;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        dbg_state;
  logic [5:0][63:0] act_wb;

  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int commit_cnt = 0;

  ysyx_22050550_wbu dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_result(in_result),
    .in_csr_op(in_csr_op), .in_csr_addr(in_csr_addr), .in_csr_src(in_csr_src),
    .mepc(mepc), .mcause(mcause), .mtvec(mtvec), .mstatus(mstatus), .mie(mie), .mip(mip),
    .io_waddr(io_waddr), .io_wdata(io_wdata), .io_wen(io_wen), .io_valid(io_valid),
    .pc(pc), .wbmepc(wbmepc), .wbmcause(wbmcause), .wbmtvec(wbmtvec),
    .wbmstatus(wbmstatus), .wbmie(wbmie), .wbmip(wbmip), .wbcsren(wbcsren),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .dbg_state(dbg_state)
  );

  assign act_wb = {wbmip, wbmie, wbmstatus, wbmtvec, wbmcause, wbmepc};

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic wen, input logic [4:0] waddr, input logic [63:0] wdata,
                              input logic [63:0] epc, input logic [7:0] csren,
                              input logic rv, input logic [63:0] rpc);
    exp_t e;
    e.wen = wen; e.waddr = waddr; e.wdata = wdata; e.pc = epc;
    e.csren = csren; e.rv = rv; e.rpc = rpc; e.wb = '0;
    return e;
  endfunction

  // driver: offer one instruction, wait for the handshake, then let the commit cycle pass
  task automatic send(input logic [63:0] ipc, input logic [4:0] rd, input logic wen,
                      input logic [63:0] res, input logic [2:0] op, input logic [11:0] addr,
                      input logic [63:0] src, input exp_t e);
    int budget;
    @(negedge clock);
    in_pc = ipc; in_rd = rd; in_rd_wen = wen; in_result = res;
    in_csr_op = op; in_csr_addr = addr; in_csr_src = src; in_valid = 1'b1;
    exp_q.push_back(e);
    budget = 0;
    while (!in_ready && budget < 20) begin
      @(negedge clock);
      budget++;
    end
    if (!in_ready) chk("send_ready_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clock);
    #1 in_valid = 1'b0;
    @(posedge clock);
    #1;
  endtask

  // monitor / scoreboard
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (io_valid) begin
        commit_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_commit_pc", pc, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_t'(exp_q.pop_front());
          chk("io_wen", {63'd0, io_wen}, {63'd0, e.wen});
          chk("io_waddr", {59'd0, io_waddr}, {59'd0, e.waddr});
          chk("io_wdata", io_wdata, e.wdata);
          chk("pc", pc, e.pc);
          chk("wbcsren", {56'd0, wbcsren}, {56'd0, e.csren});
          chk("redirect_valid", {63'd0, redirect_valid}, {63'd0, e.rv});
          if (e.rv) chk("redirect_pc", redirect_pc, e.rpc);
          for (int i = 0; i < 6; i++)
            if (e.csren[i]) chk($sformatf("wb_csr%0d", i), act_wb[i], e.wb[i]);
        end
      end else begin
        chk("idle_strobes", {54'd0, io_wen, wbcsren, redirect_valid}, 64'd0);
      end
    end
  end

  initial begin
    exp_t e;
    int c0;

    // reset state
    @(negedge clock);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_io_valid", {63'd0, io_valid}, 64'd0);
    chk("rst_pc", pc, 64'd0);
    chk("rst_io_wdata", io_wdata, 64'd0);
    chk("rst_wbcsren", {56'd0, wbcsren}, 64'd0);
    chk("rst_redirect", {63'd0, redirect_valid}, 64'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clock);
    #1;

    // addi-style
    send(64'h8000_0000, 5'd5, 1'b1, 64'h1234, 3'd0, 12'h000, 64'd0,
         mk(1'b1, 5'd5, 64'h1234, 64'h8000_0000, 8'h00, 1'b0, 64'd0));
    // rd=0 write suppressed
    send(64'h8000_0004, 5'd0, 1'b1, 64'h55, 3'd0, 12'h000, 64'd0,
         mk(1'b0, 5'd0, 64'h55, 64'h8000_0004, 8'h00, 1'b0, 64'd0));
    // op 6 behaves as no CSR op
    send(64'h8000_0008, 5'd9, 1'b1, 64'hABC, 3'd6, 12'h300, 64'hF,
         mk(1'b1, 5'd9, 64'hABC, 64'h8000_0008, 8'h00, 1'b0, 64'd0));

    // csrrs mstatus, src 8
    mstatus = 64'hA_0000_1800;
    e = mk(1'b1, 5'd7, 64'hA_0000_1800, 64'h8000_000C, 8'h08, 1'b0, 64'd0);
    e.wb[3] = 64'hA_0000_1808;
    send(64'h8000_000C, 5'd7, 1'b1, 64'h0, 3'd2, 12'h300, 64'h8, e);
    // csrrs with src 0: read only
    send(64'h8000_0010, 5'd7, 1'b1, 64'h0, 3'd2, 12'h300, 64'h0,
         mk(1'b1, 5'd7, 64'hA_0000_1800, 64'h8000_0010, 8'h00, 1'b0, 64'd0));

    // csrrw mtvec
    mtvec = 64'h8000_0201;
    e = mk(1'b1, 5'd3, 64'h8000_0201, 64'h8000_0014, 8'h04, 1'b0, 64'd0);
    e.wb[2] = 64'h8000_0300;
    send(64'h8000_0014, 5'd3, 1'b1, 64'h0, 3'd1, 12'h305, 64'h8000_0300, e);
    // csrrc mie
    mie = 64'h888;
    e = mk(1'b1, 5'd4, 64'h888, 64'h8000_0018, 8'h10, 1'b0, 64'd0);
    e.wb[4] = 64'h880;
    send(64'h8000_0018, 5'd4, 1'b1, 64'h0, 3'd3, 12'h304, 64'h8, e);
    // csrrw mip
    mip = 64'h0;
    e = mk(1'b1, 5'd10, 64'h0, 64'h8000_001C, 8'h20, 1'b0, 64'd0);
    e.wb[5] = 64'h80;
    send(64'h8000_001C, 5'd10, 1'b1, 64'h0, 3'd1, 12'h344, 64'h80, e);
    // csrrw mepc, csrrs mcause src 0
    mepc = 64'h8000_0104;
    e = mk(1'b1, 5'd11, 64'h8000_0104, 64'h8000_0020, 8'h01, 1'b0, 64'd0);
    e.wb[0] = 64'h8000_0400;
    send(64'h8000_0020, 5'd11, 1'b1, 64'h0, 3'd1, 12'h341, 64'h8000_0400, e);
    mcause = 64'h8000_0000_0000_0007;
    send(64'h8000_0024, 5'd12, 1'b1, 64'h0, 3'd2, 12'h342, 64'h0,
         mk(1'b1, 5'd12, 64'h8000_0000_0000_0007, 64'h8000_0024, 8'h00, 1'b0, 64'd0));
    // unknown CSR: reads 0, never written
    send(64'h8000_0028, 5'd13, 1'b1, 64'h99, 3'd1, 12'h123, 64'h5,
         mk(1'b1, 5'd13, 64'h0, 64'h8000_0028, 8'h00, 1'b0, 64'd0));

    // ecall
    mstatus = 64'hA_0000_1808;
    e = mk(1'b0, 5'd1, 64'h0, 64'h8000_0100, 8'h0B, 1'b1, 64'h8000_0200);
    e.wb[0] = 64'h8000_0100;
    e.wb[1] = 64'd11;
    e.wb[3] = 64'hA_0000_1880;
    send(64'h8000_0100, 5'd1, 1'b1, 64'h0, 3'd4, 12'h000, 64'h0, e);

    // mret
    mepc = 64'h8000_0104;
    mstatus = 64'hA_0000_1880;
    e = mk(1'b0, 5'd0, 64'h0, 64'h8000_0200, 8'h08, 1'b1, 64'h8000_0104);
    e.wb[3] = 64'hA_0000_1888;
    send(64'h8000_0200, 5'd0, 1'b0, 64'h0, 3'd5, 12'h000, 64'h0, e);

    // in_valid held for 4 cycles: exactly two commits, in_ready 1,0,1,0
    c0 = commit_cnt;
    @(negedge clock);
    in_pc = 64'h8000_0300; in_rd = 5'd6; in_rd_wen = 1'b1; in_result = 64'h77;
    in_csr_op = 3'd0; in_csr_addr = 12'h000; in_csr_src = 64'd0; in_valid = 1'b1;
    e = mk(1'b1, 5'd6, 64'h77, 64'h8000_0300, 8'h00, 1'b0, 64'd0);
    exp_q.push_back(e);
    exp_q.push_back(e);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clock);
      chk($sformatf("hs_ready%0d", i), {63'd0, in_ready}, {63'd0, (i % 2) == 0});
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
    chk("hs_commit_count", 64'(commit_cnt - c0), 64'd2);

    // reset pulsed mid-COMMIT of an ecall
    c0 = commit_cnt;
    @(negedge clock);
    in_pc = 64'h8000_0400; in_rd = 5'd8; in_rd_wen = 1'b1; in_result = 64'h1;
    in_csr_op = 3'd4; in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    #1 reset = 1'b1;
    @(negedge clock);
    chk("abort_io_valid", {63'd0, io_valid}, 64'd0);
    chk("abort_io_wen", {63'd0, io_wen}, 64'd0);
    chk("abort_wbcsren", {56'd0, wbcsren}, 64'd0);
    chk("abort_redirect", {63'd0, redirect_valid}, 64'd0);
    chk("abort_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("release_in_ready", {63'd0, in_ready}, 64'd1);
    chk("release_state", {63'd0, dbg_state}, 64'd0);
    repeat (2) @(negedge clock);
    chk("abort_commit_count", 64'(commit_cnt - c0), 64'd0);

    // one more ordinary instruction after the aborted one
    send(64'h8000_0500, 5'd31, 1'b1, 64'hDEAD_BEEF, 3'd0, 12'h000, 64'd0,
         mk(1'b1, 5'd31, 64'hDEAD_BEEF, 64'h8000_0500, 8'h00, 1'b0, 64'd0));

    repeat (4) @(negedge clock);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_22050550_wbu.md
# ysyx_22050550_wbu

Write-back unit of the multicycle RV64 core. It accepts one retired instruction from the LSU stage over a valid/ready handshake and latches it. In the following cycle it drives the register-file/CSR write ports of the register block (GPR write, commit PC, per-CSR write enables), and for ecall/mret it drives a PC redirect to the fetch stage.

## Interface
- Parameters: none.
- clock  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  LSU offers an instruction.
- in_ready  out  1  WBU can accept this cycle.
- in_pc  in  64  PC of the offered instruction.
- in_rd  in  5  destination GPR.
- in_rd_wen  in  1  instruction writes a GPR.
- in_result  in  64  ALU or load result.
- in_csr_op  in  3  0 none, 1 csrrw, 2 csrrs, 3 csrrc, 4 ecall, 5 mret; 6 and 7 are treated as 0.
- in_csr_addr  in  12  CSR number.
- in_csr_src  in  64  rs1 value or zero-extended zimm.
- mepc, mcause, mtvec, mstatus, mie, mip  in  64 each  current CSR values from the register block.
- io_waddr  out  5  GPR write address.
- io_wdata  out  64  GPR write data.
- io_wen  out  1  GPR write enable.
- io_valid  out  1  commit strobe.
- pc  out  64  committed PC.
- wbmepc, wbmcause, wbmtvec, wbmstatus, wbmie, wbmip  out  64 each  CSR write data.
- wbcsren  out  8  CSR write enables: bit0 mepc, bit1 mcause, bit2 mtvec, bit3 mstatus, bit4 mie, bit5 mip; bits 7:6 are always 0.
- redirect_valid  out  1  fetch must jump.
- redirect_pc  out  64  jump target.

## Operation
- FSM states: IDLE and COMMIT.
  - IDLE: in_ready=1. If in_valid is high at the edge, latch all in_* fields and go to COMMIT.
  - COMMIT: in_ready=0. Go to IDLE unconditionally at the next edge.
- All write outputs are combinational from the latch and are gated by the state. In IDLE: io_wen, io_valid, wbcsren, and redirect_valid are 0. Data outputs may hold stale values.
- COMMIT common outputs: io_valid=1, pc=latched pc.
- CSR read mux (on the latched address): 0x300 mstatus, 0x304 mie, 0x305 mtvec, 0x341 mepc, 0x342 mcause, 0x344 mip.
  - Any other address reads 0 and is never written. No fault is raised.
- csrrw: new = src.
- csrrs: new = old | src.
- csrrc: new = old & ~src.
- CSR write enable:
  - csrrw: always, for the addressed CSR.
  - csrrs/csrrc: only when src ≠ 0.
  - The selected CSR's wb* output is driven with new.
- For CSR ops, GPR write data is the old CSR value. Otherwise it is in_result.
- io_wen = COMMIT & latched rd_wen & rd≠0 & op∉{ecall, mret}. io_waddr = latched rd.
- ecall:
  - wbmepc = pc.
  - wbmcause = 11.
  - wbmstatus = mstatus with MPIE(bit7) ← MIE(bit3), MIE ← 0, MPP(12:11) ← 2'b11.
  - wbcsren = 8'b0000_1011.
  - redirect_pc = mtvec & ~64'h3.
- mret:
  - wbmstatus = mstatus with MIE ← MPIE, MPIE ← 1, MPP ← 2'b11.
  - wbcsren = 8'b0000_1000.
  - redirect_pc = mepc.
- redirect_valid=1 only in COMMIT for ecall/mret.
- CSR input values are sampled combinationally during COMMIT, i.e. the values after all earlier instructions committed.

## Timing
- Accept at edge N → COMMIT during cycle N+1. The register block samples all writes at edge N+1. in_ready returns to 1 in cycle N+2.
- Throughput: one instruction per 2 cycles. Latency from accept to architectural update: 1 cycle.
- Back-to-back CSR write then read: the second instruction's COMMIT sees the updated value.
- Reset (asynchronous) forces IDLE and clears the latch to 0. All outputs are then 0 and in_ready is 0 while reset is held. in_ready is 1 from the first cycle after deassertion.
- Reset asserted during COMMIT: the commit is aborted immediately and no enable pulses.
- in_valid high while in COMMIT: ignored; the LSU must hold the instruction until in_ready.

## Test plan
- addi-style: in_rd=5, in_rd_wen=1, in_result=0x1234, op 0 → next cycle io_wen=1, io_waddr=5, io_wdata=0x1234, io_valid=1, pc=in_pc, wbcsren=0.
- rd=0 write: in_rd=0, in_rd_wen=1 → io_wen=0, io_valid=1.
- csrrs 0x300, src 0x8, mstatus=0xA00001800 → wbmstatus=0xA00001808, wbcsren=0x08, io_wdata=0xA00001800. Repeat with src=0 → wbcsren=0.
- ecall, pc=0x80000100, mtvec=0x80000201, mstatus=0xA00001808 → wbmepc=0x80000100, wbmcause=11, wbmstatus=0xA00001880, wbcsren=0x0B, redirect_pc=0x80000200, io_wen=0.
- mret, mepc=0x80000104, mstatus=0xA00001880 → wbmstatus=0xA00001888, redirect_pc=0x80000104, redirect_valid for exactly one cycle.
- Handshake/reset: in_valid held high for 4 cycles → exactly 2 commits, in_ready toggling 1,0,1,0. Reset pulsed mid-COMMIT → no enable pulses, in_ready=1 after release.
